// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared FSM state type, AES block/key widths and index-width helper
package aes_arb_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_KEY_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_rr_pick.sv
// aes_rr_pick: combinational round-robin picker, first request at or after i_ptr wins
module aes_rr_pick
    import aes_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    logic w_found;

    // walk the requesters starting at i_ptr, wrapping, and take the first one set
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int c;
            c = (int'(i_ptr) + i) % NUM_REQ;
            if (!w_found && i_req[c]) begin
                o_grant[c] = 1'b1;
                o_idx      = IDX_W'(c);
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_arbiter.sv
// aes_arbiter: round-robin front end sharing one AES core among NUM_REQ requesters.
// Define AES_ARB_TIMEOUT_EN to add a RUN-state watchdog that returns an error response.
module aes_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_mode,
    input  logic [NUM_REQ*AES_KEY_W-1:0]   req_key,
    input  logic [NUM_REQ*AES_BLK_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]             resp_valid,
    input  logic [NUM_REQ-1:0]             resp_ready,
    output logic [AES_BLK_W-1:0]           resp_data,
    output logic                           resp_error,
    output logic                           core_reset,
    output logic                           core_enable,
    output logic                           core_mode,
    output logic [AES_KEY_W-1:0]           core_key,
    output logic [AES_BLK_W-1:0]           core_data_in,
    input  logic [AES_BLK_W-1:0]           core_data_out,
    input  logic                           core_done
);

    localparam int IDX_W = idx_w(NUM_REQ);

    arb_state_t           r_state;
    arb_state_t           w_next;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_grant_idx;
    logic [IDX_W-1:0]     w_pick_idx;
    logic [NUM_REQ-1:0]   r_grant_oh;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic                 r_mode;
    logic [AES_KEY_W-1:0] r_key;
    logic [AES_BLK_W-1:0] r_data;
    logic [AES_BLK_W-1:0] r_resp_data;
    logic                 r_core_reset;
    logic                 w_any;
    logic                 w_grant;
    logic                 w_hs;
    logic                 w_tmo;
    logic                 w_err;
    logic                 w_busy;

    aes_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_oh),
        .o_idx   (w_pick_idx)
    );

    assign w_any   = |req_valid;
    assign w_grant = (r_state == ST_IDLE) && w_any;
    assign w_hs    = (r_state == ST_RESP) && |(resp_ready & r_grant_oh);

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_resp_error;

    assign w_tmo = (r_state == ST_RUN) && !core_done && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_err = r_resp_error;

    // watchdog: cleared while loading, counts every RUN cycle; error flag lives until the handshake
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tmo_cnt    <= '0;
            r_resp_error <= 1'b0;
        end else begin
            r_tmo_cnt    <= (r_state == ST_LOAD) ? '0 : (r_state == ST_RUN) ? r_tmo_cnt + 1'b1 : r_tmo_cnt;
            r_resp_error <= w_tmo ? 1'b1 : (w_hs || w_grant) ? 1'b0 : r_resp_error;
        end
    end
`else
    assign w_tmo = 1'b0 && (TIMEOUT_CYCLES > 0);
    assign w_err = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // next-state: one job at a time, RUN waits for done (or the watchdog)
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: w_next = w_any ? ST_LOAD : ST_IDLE;
            ST_LOAD: w_next = ST_RUN;
            ST_RUN:  w_next = (core_done || w_tmo) ? ST_RESP : ST_RUN;
            ST_RESP: w_next = w_hs ? ST_IDLE : ST_RESP;
            default: w_next = ST_IDLE;
        endcase
    end

    // operand latch at grant, result capture in RUN, pointer advance on handshake
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr_ptr     <= '0;
            r_grant_idx  <= '0;
            r_grant_oh   <= '0;
            r_mode       <= 1'b0;
            r_key        <= '0;
            r_data       <= '0;
            r_resp_data  <= '0;
            r_core_reset <= 1'b1;
        end else begin
            r_core_reset <= (w_next == ST_LOAD);
            if (w_grant) begin
                r_grant_idx <= w_pick_idx;
                r_grant_oh  <= w_pick_oh;
                r_mode      <= |(req_mode & w_pick_oh);
                r_key       <= req_key[AES_KEY_W*w_pick_idx +: AES_KEY_W];
                r_data      <= req_data[AES_BLK_W*w_pick_idx +: AES_BLK_W];
            end
            if (r_state == ST_RUN && core_done) r_resp_data <= core_data_out;
            else if (w_tmo)                     r_resp_data <= '0;
            if (w_hs) r_rr_ptr <= (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_idx + 1'b1;
        end
    end

    // outputs: everything quiet in IDLE except the combinational accept strobe
    always_comb begin
        w_busy       = (r_state != ST_IDLE);
        req_ready    = (r_state == ST_IDLE && reset) ? w_pick_oh : '0;
        resp_valid   = (r_state == ST_RESP) ? r_grant_oh : '0;
        resp_data    = (r_state == ST_RESP) ? r_resp_data : '0;
        resp_error   = (r_state == ST_RESP) && w_err;
        core_reset   = r_core_reset;
        core_enable  = (r_state == ST_RUN);
        core_mode    = w_busy && r_mode;
        core_key     = w_busy ? r_key : '0;
        core_data_in = w_busy ? r_data : '0;
    end

endmodule

// File: tb/tb_aes_arbiter.sv
// tb_aes_arbiter: directed bench for aes_arbiter; the bench plays the AES core
module tb_aes_arbiter;

    localparam int N = 4;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] DAT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RES = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid, req_ready, req_mode, resp_valid, resp_ready;
    logic [N*128-1:0] req_key, req_data;
    logic [127:0]   resp_data, core_key, core_data_in, core_data_out;
    logic           resp_error, core_reset, core_enable, core_mode, core_done;
    int             n_chk = 0;
    int             n_err = 0;

    always #5 clk = ~clk;

    aes_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_key(req_key), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_error(resp_error),
        .core_reset(core_reset), .core_enable(core_enable), .core_mode(core_mode),
        .core_key(core_key), .core_data_in(core_data_in),
        .core_data_out(core_data_out), .core_done(core_done)
    );

    function automatic logic [127:0] kf(input int i);
        return {4{32'hC0DE_0000 | i}};
    endfunction

    function automatic logic [127:0] df(input int i);
        return {4{32'hDA7A_0000 | i}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 128'(req_ready), 128'h0);
        chk({tag, "_resp_valid"}, 128'(resp_valid), 128'h0);
        chk({tag, "_resp_data"}, resp_data, 128'h0);
        chk({tag, "_resp_error"}, 128'(resp_error), 128'h0);
        chk({tag, "_core_enable"}, 128'(core_enable), 128'h0);
        chk({tag, "_core_reset"}, 128'(core_reset), 128'h1);
        chk({tag, "_core_mode"}, 128'(core_mode), 128'h0);
        chk({tag, "_core_key"}, core_key, 128'h0);
        chk({tag, "_core_data_in"}, core_data_in, 128'h0);
    endtask

    task automatic rr_job(input int w);
        logic [N-1:0]  oh;
        logic [127:0]  r;
        oh = N'(1 << w);
        r  = df(w) ^ {4{32'h5A5A_A5A5}};
        chk("rr_req_ready", 128'(req_ready), 128'(oh));
        step();
        chk("rr_core_mode", 128'(core_mode), 128'(req_mode[w]));
        chk("rr_core_key", core_key, kf(w));
        step();
        core_data_out = r;
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        #1;
        chk("rr_resp_valid", 128'(resp_valid), 128'(oh));
        chk("rr_resp_data", resp_data, r);
        resp_ready = oh;
        step();
        resp_ready = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0;
        req_mode = '0;
        resp_ready = '0;
        core_done = 1'b0;
        core_data_out = '0;
        for (int i = 0; i < N; i++) begin
            req_key[128*i +: 128] = kf(i);
            req_data[128*i +: 128] = df(i);
        end
        step(2);
        chk_reset_vals("rst");
        reset = 1'b1;
        step();
        chk("idle_core_reset", 128'(core_reset), 128'h0);
        chk("idle_req_ready", 128'(req_ready), 128'h0);
        chk("idle_core_enable", 128'(core_enable), 128'h0);

        req_key[256 +: 128] = KEY;
        req_data[256 +: 128] = DAT;
        req_valid = 4'b0100;
        #1;
        chk("single_req_ready", 128'(req_ready), 128'h4);
        step();
        req_valid = '0;
        req_key[256 +: 128] = ~KEY;
        req_data[256 +: 128] = ~DAT;
        #1;
        chk("load_core_reset", 128'(core_reset), 128'h1);
        chk("load_core_enable", 128'(core_enable), 128'h0);
        chk("load_req_ready", 128'(req_ready), 128'h0);
        chk("load_core_key", core_key, KEY);
        chk("load_core_data", core_data_in, DAT);
        chk("load_core_mode", 128'(core_mode), 128'h0);
        step();
        chk("run_core_reset", 128'(core_reset), 128'h0);
        chk("run_core_enable", 128'(core_enable), 128'h1);
        chk("run_core_key", core_key, KEY);
        step(3);
        chk("run_wait_enable", 128'(core_enable), 128'h1);
        chk("run_no_resp", 128'(resp_valid), 128'h0);
        core_data_out = RES;
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        core_data_out = '1;
        #1;
        chk("resp_valid", 128'(resp_valid), 128'h4);
        chk("resp_data", resp_data, RES);
        chk("resp_core_enable", 128'(core_enable), 128'h0);
        chk("resp_error", 128'(resp_error), 128'h0);
        for (int c = 0; c < 10; c++) begin
            resp_ready = (c == 4) ? 4'b1011 : 4'b0000;
            step();
            chk("hold_resp_valid", 128'(resp_valid), 128'h4);
            chk("hold_resp_data", resp_data, RES);
        end
        resp_ready = 4'b0100;
        step();
        resp_ready = '0;
        chk("hs_resp_valid", 128'(resp_valid), 128'h0);
        chk("hs_core_key", core_key, 128'h0);

        req_valid = 4'b0001;
        #1;
        chk("sole_req_ready", 128'(req_ready), 128'h1);
        step();
        req_valid = '0;
        step(2);
        chk("midrun_enable", 128'(core_enable), 128'h1);
        reset = 1'b0;
        step();
        chk_reset_vals("midrun_rst");
        reset = 1'b1;
        step(3);
        chk("post_rst_resp_valid", 128'(resp_valid), 128'h0);
        chk("post_rst_enable", 128'(core_enable), 128'h0);

        req_key[256 +: 128] = kf(2);
        req_data[256 +: 128] = df(2);
        req_mode = 4'b1010;
        req_valid = 4'b1111;
        #1;
        for (int j = 0; j < 5; j++) rr_job(j % 4);
        req_valid = '0;
        req_mode = '0;
        step();

        req_valid = 4'b1000;
        #1;
        chk("tmo_req_ready", 128'(req_ready), 128'h8);
        step();
        req_valid = '0;
        step();
`ifdef AES_ARB_TIMEOUT_EN
        step(31);
        chk("tmo_still_run", 128'(core_enable), 128'h1);
        chk("tmo_no_resp_yet", 128'(resp_valid), 128'h0);
        step();
        chk("tmo_resp_valid", 128'(resp_valid), 128'h8);
        chk("tmo_resp_error", 128'(resp_error), 128'h1);
        chk("tmo_resp_data", resp_data, 128'h0);
        chk("tmo_core_enable", 128'(core_enable), 128'h0);
        resp_ready = 4'b1000;
        step();
        resp_ready = '0;
        chk("tmo_err_clear", 128'(resp_error), 128'h0);
        chk("tmo_hs_valid", 128'(resp_valid), 128'h0);
`else
        step(40);
        chk("notmo_run_enable", 128'(core_enable), 128'h1);
        chk("notmo_no_resp", 128'(resp_valid), 128'h0);
        chk("notmo_no_error", 128'(resp_error), 128'h0);
        reset = 1'b0;
        step();
        chk_reset_vals("notmo_rst");
        reset = 1'b1;
        step();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/aes_arbiter.md
AES_ARBITER -- requirements
Module: aes_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, sets the number of requesters (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 32, is the core watchdog limit in cycles (used only when AES_ARB_TIMEOUT_EN is defined).
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 Port req_valid, input, NUM_REQ bits: per-requester job request.
REQ-006 Port req_ready, output, NUM_REQ bits: one-hot accept strobe to the granted requester.
REQ-007 Port req_mode, input, NUM_REQ bits: per-requester mode; 0 is encrypt, 1 is decrypt.
REQ-008 Port req_key, input, NUM_REQ*128 bits: key of requester i in bits [128*i+:128].
REQ-009 Port req_data, input, NUM_REQ*128 bits: data block of requester i in bits [128*i+:128].
REQ-010 Port resp_valid, output, NUM_REQ bits: one-hot result strobe to the owning requester.
REQ-011 Port resp_ready, input, NUM_REQ bits: per-requester result acceptance.
REQ-012 Port resp_data, output, 128 bits: result block, shared by all requesters.
REQ-013 Port resp_error, output, 1 bit: the result is invalid because of a core timeout.
REQ-014 Port core_reset, output, 1 bit: active-high clear pulse to the AES core.
REQ-015 Port core_enable, output, 1 bit: run enable to the AES core.
REQ-016 Port core_mode, output, 1 bit: mode to the AES core.
REQ-017 Port core_key, output, 128 bits: key to the AES core.
REQ-018 Port core_data_in, output, 128 bits: data block to the AES core.
REQ-019 Port core_data_out, input, 128 bits: result from the AES core.
REQ-020 Port core_done, input, 1 bit: completion flag from the AES core.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, RUN and RESP, encoded in 2 bits.
REQ-022 In IDLE with any req_valid set, the FSM SHALL grant round-robin, starting the search at index rr_ptr, assert req_ready for the winner combinationally in that cycle, latch the winner's mode, key and data, and go to LOAD.
REQ-023 In IDLE with no req_valid set, the FSM SHALL stay in IDLE, all outputs inactive.
REQ-024 LOAD SHALL last exactly 1 cycle, with core_reset=1 and core_enable=0, then go to RUN.
REQ-025 From LOAD onward, core_mode, core_key and core_data_in SHALL be driven from the latched operands and held stable until the FSM returns to IDLE.
REQ-026 In RUN, core_enable=1; on the first cycle core_done=1, the block SHALL capture core_data_out into resp_data, drop core_enable the next cycle, and go to RESP.
REQ-027 In RESP, resp_valid[grant]=1 and resp_data SHALL hold stable until resp_ready[grant]=1.
REQ-028 On the resp_ready[grant] handshake, the FSM SHALL return to IDLE and set rr_ptr = (grant+1) mod NUM_REQ.
REQ-029 resp_ready bits of non-granted requesters SHALL be ignored.
REQ-030 A requester dropping req_valid after its grant SHALL not abort the job.
REQ-031 Only one job SHALL be in flight; req_ready SHALL be 0 in LOAD, RUN and RESP.
REQ-032 With simultaneous requests, the index nearest at-or-after rr_ptr (modulo) SHALL win; a sole requester SHALL win regardless of rr_ptr.
REQ-033 Back-to-back jobs SHALL be allowed: IDLE may grant in the cycle after the RESP handshake.

Reset
REQ-034 While reset=0 at a clock edge, the block SHALL set: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_data=0, resp_error=0, core_enable=0, core_reset=1, core_mode=0, core_key=0, core_data_in=0.
REQ-035 Reset mid-job SHALL discard the job with no response; the requester must re-request.

Configuration
REQ-036 With AES_ARB_TIMEOUT_EN defined, a cycle counter SHALL clear on RUN entry and increment each RUN cycle.
REQ-037 With AES_ARB_TIMEOUT_EN defined, on reaching TIMEOUT_CYCLES without core_done, the FSM SHALL go to RESP with resp_data=0 and resp_error=1.
REQ-038 With AES_ARB_TIMEOUT_EN defined, resp_error SHALL clear on the RESP handshake.
REQ-039 Without AES_ARB_TIMEOUT_EN, no counter SHALL exist, resp_error SHALL be tied to 0, and RUN SHALL wait indefinitely.

Structure
REQ-040 Package aes_arb_pkg SHALL hold the FSM state typedef, the state encodings, and constants AES_BLK_W=128 and AES_KEY_W=128.
REQ-041 Sub-module aes_rr_pick SHALL implement the combinational round-robin one-hot picker (inputs req vector and rr_ptr; outputs one-hot grant and grant index).

Verification
REQ-042 Single requester: req_valid=4'b0100, key=000102..0f, data=00112233..ff, mode=0 -> req_ready=4'b0100 same cycle, 1-cycle core_reset, resp_valid=4'b0100 with resp_data=69c4e0d8..c55a after core_done.
REQ-043 All four requesting continuously: grants SHALL occur in order 0,1,2,3,0; no requester is granted twice before the others.
REQ-044 resp_ready held low for 10 cycles in RESP -> resp_valid and resp_data SHALL stay stable; a stray resp_ready on a non-granted index has no effect.
REQ-045 reset=0 asserted in RUN -> next cycle state=IDLE, all outputs at reset values, no resp_valid.
REQ-046 With AES_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=32, core_done stuck at 0 -> RESP entered after 32 RUN cycles with resp_error=1 and resp_data=0; without the macro, the FSM stays in RUN.
